// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: loads a start value, borrows down one second per
// enabled tick while running, and pulses done when the count reaches 00:00.
module countdown_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_t,
    input  logic [3:0] ld_min_u,
    input  logic [3:0] ld_sec_t,
    input  logic [3:0] ld_sec_u,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_t_q, min_t_d;
    logic [3:0] min_u_q, min_u_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] sec_u_q, sec_u_d;
    logic       running_q, zero_q, done_q, done_d;
    logic       is_zero_s, is_one_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign is_zero_s = (min_t_q == 4'd0) && (min_u_q == 4'd0) &&
                       (sec_t_q == 4'd0) && (sec_u_q == 4'd0);
    assign is_one_s  = (min_t_q == 4'd0) && (min_u_q == 4'd0) &&
                       (sec_t_q == 4'd0) && (sec_u_q == 4'd1);

    // Next state and next digits; only the highest-priority command acts.
    always_comb begin
        state_d = state_q;
        min_t_d = min_t_q;
        min_u_d = min_u_q;
        sec_t_d = sec_t_q;
        sec_u_d = sec_u_q;
        done_d  = 1'b0;
        if (load) begin
            min_t_d = clamp_digit(ld_min_t, 4'd5);
            min_u_d = clamp_digit(ld_min_u, 4'd9);
            sec_t_d = clamp_digit(ld_sec_t, 4'd5);
            sec_u_d = clamp_digit(ld_sec_u, 4'd9);
            state_d = ST_IDLE;
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end else begin
                state_d = state_q;
            end
        end else if (start) begin
            case (state_q)
                ST_IDLE:  state_d = is_zero_s ? ST_IDLE : ST_RUN;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end else if (tick && (state_q == ST_RUN) && !is_zero_s) begin
            // Borrow ripples units-to-tens; 00:00 is never decremented, so min_t never wraps.
            if (sec_u_q == 4'd0) begin
                sec_u_d = 4'd9;
                if (sec_t_q == 4'd0) begin
                    sec_t_d = 4'd5;
                    if (min_u_q == 4'd0) begin
                        min_u_d = 4'd9;
                        min_t_d = min_t_q - 4'd1;
                    end else begin
                        min_u_d = min_u_q - 4'd1;
                    end
                end else begin
                    sec_t_d = sec_t_q - 4'd1;
                end
            end else begin
                sec_u_d = sec_u_q - 4'd1;
            end
            if (is_one_s) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, digit and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            min_t_q   <= 4'd0;
            min_u_q   <= 4'd0;
            sec_t_q   <= 4'd0;
            sec_u_q   <= 4'd0;
            running_q <= 1'b0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_t_q   <= min_t_d;
            min_u_q   <= min_u_d;
            sec_t_q   <= sec_t_d;
            sec_u_q   <= sec_u_d;
            running_q <= (state_d == ST_RUN);
            zero_q    <= (min_t_d == 4'd0) && (min_u_d == 4'd0) &&
                         (sec_t_d == 4'd0) && (sec_u_d == 4'd0);
            done_q    <= done_d;
        end
    end

    assign min_t   = min_t_q;
    assign min_u   = min_u_q;
    assign sec_t   = sec_t_q;
    assign sec_u   = sec_u_q;
    assign running = running_q;
    assign zero    = zero_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; digits are compared as a
// packed 16-bit {min_t, min_u, sec_t, sec_u} value against hand-computed BCD.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_min_t = 4'd0;
    logic [3:0] ld_min_u = 4'd0;
    logic [3:0] ld_sec_t = 4'd0;
    logic [3:0] ld_sec_u = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, zero, done;
    logic [15:0] val;

    int n_checks = 0;
    int n_fails  = 0;

    countdown_timer dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .ld_min_t(ld_min_t), .ld_min_u(ld_min_u),
        .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
        .start(start), .pause(pause),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .zero(zero), .done(done)
    );

    always #5 clk = ~clk;

    assign val = {min_t, min_u, sec_t, sec_u};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input logic with_tick);
        ld_min_t = a; ld_min_u = b; ld_sec_t = c; ld_sec_u = d;
        load = 1'b1; tick = with_tick;
        step();
        load = 1'b0; tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
    endtask

    initial begin
        int  n_tk;
        bit  found;

        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_val", val, 16'h0000);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_zero", zero, 1'b1);

        do_load(4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        chk("load_0100", val, 16'h0100);
        chk("load_zero", zero, 1'b0);
        start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
        chk("start_tick_nodec", val, 16'h0100);
        chk("start_running", running, 1'b1);
        do_ticks(1);
        chk("tick_0059", val, 16'h0059);
        chk("tick_done0", done, 1'b0);
        do_ticks(3);
        chk("tick_0056", val, 16'h0056);

        do_load(4'd0, 4'd0, 4'd0, 4'd2, 1'b0);
        do_start();
        do_ticks(1);
        chk("exp_0001", val, 16'h0001);
        chk("exp_pre_done", done, 1'b0);
        do_ticks(1);
        chk("exp_val", val, 16'h0000);
        chk("exp_done", done, 1'b1);
        chk("exp_zero", zero, 1'b1);
        chk("exp_running", running, 1'b0);
        step();
        chk("exp_done_pulse", done, 1'b0);
        do_ticks(5);
        chk("done_hold_val", val, 16'h0000);
        chk("done_hold_done", done, 1'b0);
        do_start();
        chk("done_start_ign", running, 1'b0);

        do_load(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        do_start();
        do_ticks(1);
        chk("borrow_0959", val, 16'h0959);

        do_load(4'd5, 4'd9, 4'd5, 4'd9, 1'b0);
        do_start();
        n_tk = 0; found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            n_tk++;
            if (done) found = 1'b1;
        end
        chk("full_count_ticks", n_tk, 3599);
        chk("full_count_val", val, 16'h0000);

        do_load(4'd7, 4'd15, 4'd6, 4'd12, 1'b0);
        chk("clamp_5959", val, 16'h5959);
        do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        do_start();
        chk("start_zero_running", running, 1'b0);
        chk("start_zero_val", val, 16'h0000);

        do_load(4'd0, 4'd0, 4'd1, 4'd0, 1'b0);
        do_start();
        do_ticks(2);
        chk("pause_pre", val, 16'h0008);
        pause = 1'b1; step(); pause = 1'b0;
        chk("pause_running", running, 1'b0);
        do_ticks(3);
        chk("pause_hold", val, 16'h0008);
        do_start();
        chk("resume_running", running, 1'b1);
        do_ticks(1);
        chk("resume_0007", val, 16'h0007);
        pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
        chk("pause_tick_val", val, 16'h0007);
        chk("pause_tick_run", running, 1'b0);

        do_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
        do_start();
        do_ticks(1);
        chk("pre_rst_0004", val, 16'h0004);
        rst = 1'b1; tick = 1'b1; step(); rst = 1'b0; tick = 1'b0;
        chk("midrst_val", val, 16'h0000);
        chk("midrst_running", running, 1'b0);
        chk("midrst_done", done, 1'b0);
        do_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
        chk("load_tick_val", val, 16'h0005);

        do_load(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
        do_start();
        do_load(4'd0, 4'd0, 4'd3, 4'd0, 1'b1);
        chk("load_vs_exp_val", val, 16'h0030);
        chk("load_vs_exp_done", done, 1'b0);
        chk("load_vs_exp_run", running, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
